// File: rtl/secded_pkg.sv
// Shared Hamming SECDED helpers: parity-bit count, codeword width, data-bit
// placement and the encoder, usable by the codec pipeline and memory wrappers.
package secded_pkg;

    localparam int MAX_CW = 64;

    function automatic int secded_p(input int data_w);
        int p;
        p = 0;
        // Descending scan leaves the smallest P that satisfies the bound.
        for (int q = 7; q >= 1; q--) begin
            if ((1 << q) >= data_w + q + 1) p = q;
        end
        return p;
    endfunction

    function automatic int secded_cw_w(input int data_w);
        return data_w + secded_p(data_w) + 1;
    endfunction

    // Hamming position of payload bit k: k-th non-power-of-two position from 3 up.
    function automatic int secded_data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 3; i < MAX_CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == k) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic logic [MAX_CW-1:0] secded_encode(input logic [MAX_CW-1:0] data,
                                                        input int data_w);
        logic [MAX_CW-1:0] cw;
        logic              par;
        int                cw_w;
        int                p;
        cw   = '0;
        cw_w = secded_cw_w(data_w);
        p    = secded_p(data_w);
        for (int k = 0; k < MAX_CW; k++) begin
            if (k < data_w) cw[secded_data_pos(k)] = data[k];
        end
        for (int j = 0; j < 7; j++) begin
            if (j < p) begin
                par = 1'b0;
                for (int i = 1; i < MAX_CW; i++) begin
                    if (i < cw_w && i[j]) par = par ^ cw[i];
                end
                cw[1 << j] = par;
            end
        end
        cw[0] = ^cw[MAX_CW-1:1];
        return cw;
    endfunction

endpackage

// File: rtl/secded_codec_dec_core.sv
// Combinational SECDED decoder: syndrome, overall parity, single-bit correction
// and payload extraction from one codeword.
module secded_dec_core
    import secded_pkg::*;
#(
    parameter  int DATA_W = 4,
    localparam int P      = secded_p(DATA_W),
    localparam int CW_W   = secded_cw_w(DATA_W)
) (
    input  logic [CW_W-1:0]   i_cw,
    output logic [DATA_W-1:0] o_datao,
    output logic [P-1:0]      o_syn,
    output logic              o_sec,
    output logic              o_ded
);

    logic [P-1:0]    w_s;
    logic            w_pz;
    logic [CW_W-1:0] w_fix;

    always_comb begin
        w_s = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (i_cw[i]) w_s = w_s ^ P'(i);
        end
        w_pz    = ^i_cw;
        w_fix   = i_cw;
        o_sec   = 1'b0;
        o_ded   = 1'b0;
        o_datao = '0;
        if (w_pz) begin
            if (w_s == '0) begin
                o_sec = 1'b1;
            end else if (int'(w_s) < CW_W) begin
                w_fix[w_s] = ~w_fix[w_s];
                o_sec      = 1'b1;
            end else begin
                // Odd weight pointing past the codeword can only be a multi-bit error.
                o_ded = 1'b1;
            end
        end else if (w_s != '0) begin
            o_ded = 1'b1;
        end
        for (int k = 0; k < DATA_W; k++) begin
            o_datao[k] = w_fix[secded_data_pos(k)];
        end
    end

    assign o_syn = w_s;

endmodule

// File: rtl/secded_codec.sv
// Three-stage SECDED encode -> error-inject -> decode pipeline with a
// valid/ready handshake and saturating SEC/DED event counters.
module secded_codec
    import secded_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 8,
    localparam int P      = secded_p(DATA_W),
    localparam int CW_W   = secded_cw_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] datai,
    input  logic [CW_W-1:0]   err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] datao,
    output logic [P-1:0]      syn,
    output logic              sec,
    output logic              ded,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_vld1, r_vld2, r_vld3;
    logic [CW_W-1:0]   r_cw1, r_err1, r_cw2;
    logic [DATA_W-1:0] r_datao;
    logic [P-1:0]      r_syn;
    logic              r_sec, r_ded;
    logic [CNT_W-1:0]  r_sec_cnt, r_ded_cnt;

    logic              w_adv;
    logic              w_xfer_out;
    logic [CW_W-1:0]   w_enc;
    logic [DATA_W-1:0] w_dec_data;
    logic [P-1:0]      w_dec_syn;
    logic              w_dec_sec, w_dec_ded;

    assign w_adv      = !r_vld3 || out_ready;
    assign w_xfer_out = r_vld3 && out_ready;
    assign w_enc      = CW_W'(secded_encode(MAX_CW'(datai), DATA_W));

    secded_dec_core #(.DATA_W(DATA_W)) u_dec (
        .i_cw    (r_cw2),
        .o_datao (w_dec_data),
        .o_syn   (w_dec_syn),
        .o_sec   (w_dec_sec),
        .o_ded   (w_dec_ded)
    );

    // The whole pipeline moves together; a stalled output freezes every stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld1  <= 1'b0;
            r_vld2  <= 1'b0;
            r_vld3  <= 1'b0;
            r_cw1   <= '0;
            r_err1  <= '0;
            r_cw2   <= '0;
            r_datao <= '0;
            r_syn   <= '0;
            r_sec   <= 1'b0;
            r_ded   <= 1'b0;
        end else if (w_adv) begin
            r_vld1 <= in_valid;
            if (in_valid) begin
                r_cw1  <= w_enc;
                r_err1 <= err;
            end
            r_vld2 <= r_vld1;
            if (r_vld1) r_cw2 <= r_cw1 ^ r_err1;
            r_vld3 <= r_vld2;
            if (r_vld2) begin
                r_datao <= w_dec_data;
                r_syn   <= w_dec_syn;
                r_sec   <= w_dec_sec;
                r_ded   <= w_dec_ded;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (cnt_clr) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (w_xfer_out) begin
            if (r_sec && r_sec_cnt != CNT_MAX) r_sec_cnt <= r_sec_cnt + CNT_W'(1);
            if (r_ded && r_ded_cnt != CNT_MAX) r_ded_cnt <= r_ded_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_vld3;
    assign datao     = r_datao;
    assign syn       = r_syn;
    assign sec       = r_sec;
    assign ded       = r_ded;
    assign sec_cnt   = r_sec_cnt;
    assign ded_cnt   = r_ded_cnt;

endmodule
